// File: rtl/gate_test_pkg.sv
// Shared types and truth tables for the 2-input gate self-test checker.
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 4;
  localparam int CNT_W       = 4;

  // Bit i is the expected output for input vector i = {a,b}.
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] XOR_TT  = 4'b0110;
  localparam logic [3:0] NAND_TT = 4'b0111;

  typedef struct packed {
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;
  } result_t;

  function automatic logic vec_mismatch(input logic [3:0] tt, input logic [1:0] idx,
                                        input logic c);
    return c ^ tt[idx];
  endfunction

endpackage

// File: rtl/and_gate.sv
// Reference 2-input AND used as the gate under test.
module and_gate (
  input  logic a,
  input  logic b,
  output logic c
);
  assign c = a & b;
endmodule

// File: rtl/settle_timer.sv
// Loadable up/down counter with synchronous clear and terminal-count compare.
module settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] term,
  output logic         tc
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr)  count <= '0;
    else if (load)   count <= load_val;
    else if (en)     count <= up ? count + ONE : count - ONE;
  end

  assign tc = (count == term);

endmodule

// File: rtl/gate_response_checker.sv
// Steps a 2-input gate through 00,01,10,11, samples its response after a
// settle interval and reports per-vector mismatches.
module gate_response_checker
  import gate_test_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] EXP_TT        = AND_TT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  // Timer counts 0..SETTLE_CYCLES-1 while in SETTLE; tc marks the last cycle.
  localparam logic [CNT_W-1:0] TERM = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0]       LAST = 2'(NUM_VECTORS - 1);

  state_t     state;
  logic [1:0] idx;
  result_t    res;
  logic       tc, t_clr, t_en;
  logic       mism;
  logic [2:0] err_nxt;
  logic       launch;

  assign launch  = start && (state == IDLE || state == DONE);
  assign t_clr   = launch || (state == SAMPLE);
  assign t_en    = (state == SETTLE);
  assign mism    = vec_mismatch(EXP_TT, idx, c);
  assign err_nxt = res.err_count + {2'b00, mism};

  settle_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (t_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (t_en),
    .up       (1'b1),
    .term     (TERM),
    .tc       (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 2'd0;
      a     <= 1'b0;
      b     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      res   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= SETTLE;
            idx   <= 2'd0;
            {a, b} <= 2'b00;
            busy  <= 1'b1;
            done  <= 1'b0;
            res   <= '0;
          end
        end
        SETTLE: begin
          if (tc) state <= SAMPLE;
        end
        SAMPLE: begin
          if (mism) begin
            res.fail_vec[idx] <= 1'b1;
            res.err_count     <= err_nxt;
          end
          if (idx == LAST) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            res.pass <= (err_nxt == 3'd0);
          end else begin
            state  <= SETTLE;
            idx    <= idx + 2'd1;
            {a, b} <= idx + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pass      = res.pass;
  assign err_count = res.err_count;
  assign fail_vec  = res.fail_vec;

endmodule

// File: tb/tb_gate_response_checker.sv
// Four checker instances (AND, OR-expected, 1- and 15-cycle settle) against a
// behavioural timeline model, plus literal checks of the headline results.
module tb_gate_response_checker;
  import gate_test_pkg::*;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, frc = 1'b0;
  always #5 clk = ~clk;

  logic       a_w[4], b_w[4], g_w[4], c_w[4], busy_w[4], done_w[4], pass_w[4];
  logic [2:0] err_w[4];
  logic [3:0] fv_w[4];

  for (genvar i = 0; i < 4; i++) begin : g_plant
    and_gate u_gate (.a(a_w[i]), .b(b_w[i]), .c(g_w[i]));
    assign c_w[i] = frc | g_w[i];
  end

  gate_response_checker dut_and (
    .clk(clk), .rst(rst), .start(start), .a(a_w[0]), .b(b_w[0]), .c(c_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err_w[0]), .fail_vec(fv_w[0]));
  gate_response_checker #(.EXP_TT(OR_TT)) dut_or (
    .clk(clk), .rst(rst), .start(start), .a(a_w[1]), .b(b_w[1]), .c(c_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err_w[1]), .fail_vec(fv_w[1]));
  gate_response_checker #(.SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .rst(rst), .start(start), .a(a_w[2]), .b(b_w[2]), .c(c_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(err_w[2]), .fail_vec(fv_w[2]));
  gate_response_checker #(.SETTLE_CYCLES(15)) dut_s15 (
    .clk(clk), .rst(rst), .start(start), .a(a_w[3]), .b(b_w[3]), .c(c_w[3]),
    .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]), .err_count(err_w[3]), .fail_vec(fv_w[3]));

  // Model: a run is just "edges since start"; vector v owns S+1 edges, the
  // last of which samples c.
  int         s_m[4]  = '{2, 2, 1, 15};
  logic [3:0] tt_m[4] = '{AND_TT, OR_TT, AND_TT, AND_TT};
  bit         run_m[4], dn_m[4];
  int         k_m[4], err_m[4];
  logic [3:0] fv_m[4];

  int tests = 0, fails = 0, cyc = 0, t0 = 0;
  int lat[4];

  task automatic model_step();
    for (int i = 0; i < 4; i++) begin
      int p, v;
      logic cexp;
      p = s_m[i] + 1;
      v = k_m[i] / p;
      if (rst) begin
        run_m[i] = 0; dn_m[i] = 0; err_m[i] = 0; fv_m[i] = '0; k_m[i] = 0;
      end else if (start && !run_m[i]) begin
        run_m[i] = 1; dn_m[i] = 0; err_m[i] = 0; fv_m[i] = '0; k_m[i] = 0;
      end else if (run_m[i]) begin
        if (k_m[i] % p == s_m[i]) begin
          cexp = frc | (v == 3);
          if (cexp != tt_m[i][v]) begin
            err_m[i]++;
            fv_m[i][v] = 1'b1;
          end
        end
        k_m[i]++;
        if (k_m[i] == 4 * p) begin
          run_m[i] = 0;
          dn_m[i]  = 1;
        end
      end
    end
  endtask

  function automatic logic [12:0] exp_of(input int i);
    logic [1:0] ab;
    ab = run_m[i] ? 2'(k_m[i] / (s_m[i] + 1)) : (dn_m[i] ? 2'b11 : 2'b00);
    return {ab, run_m[i], dn_m[i], dn_m[i] && (err_m[i] == 0), 3'(err_m[i]), fv_m[i]};
  endfunction

  function automatic logic [12:0] got_of(input int i);
    return {a_w[i], b_w[i], busy_w[i], done_w[i], pass_w[i], err_w[i], fv_w[i]};
  endfunction

  function automatic int res_of(input int i);
    return int'({pass_w[i], err_w[i], fv_w[i]});
  endfunction

  // One clock edge: advance the model with the inputs the DUT sampled, then
  // compare every instance once its registers have settled.
  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #2;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (got_of(i) !== exp_of(i)) begin
        fails++;
        $display("FAIL model[%0d] cyc %0d: got {ab,busy,done,pass,err,fv}=%b, want %b",
                 i, cyc, got_of(i), exp_of(i));
      end
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  task automatic begin_run();
    start = 1'b1;
    tick();
    t0 = cyc;
    start = 1'b0;
  endtask

  // Record, per instance, edges from the start edge until done is first seen.
  task automatic run_wait(input int limit);
    for (int i = 0; i < 4; i++) lat[i] = -1;
    for (int n = 0; n < limit; n++) begin
      bit all_seen;
      tick();
      all_seen = 1;
      for (int i = 0; i < 4; i++) begin
        if (done_w[i] && lat[i] < 0) lat[i] = cyc - t0;
        if (lat[i] < 0) all_seen = 0;
      end
      if (all_seen) break;
    end
  endtask

  initial begin
    #2;
    tick(); tick();
    rst = 1'b0;
    chk("reset_state", int'(got_of(0)), 0);

    // Default run on all four: latency in "cycle t+N" terms is lat+1.
    begin_run();
    run_wait(90);
    chk("and_done_at_t+13", lat[0] + 1, 13);
    chk("and_result",       res_of(0), int'({1'b1, 3'd0, 4'b0000}));
    chk("or_result",        res_of(1), int'({1'b0, 3'd2, 4'b0110}));
    chk("s1_done_at_t+9",   lat[2] + 1, 9);
    chk("s1_pass",          int'(pass_w[2]), 1);
    chk("s15_done_at_t+65", lat[3] + 1, 65);
    chk("s15_pass",         int'(pass_w[3]), 1);

    // c stuck high against AND expectations.
    frc = 1'b1;
    begin_run();
    run_wait(90);
    chk("stuck1_result", res_of(0), int'({1'b0, 3'd3, 4'b0111}));
    frc = 1'b0;

    // Start while DONE discards the previous result.
    begin_run();
    chk("restart_clears", int'({busy_w[0], done_w[0], err_w[0], fv_w[0]}),
        int'({1'b1, 1'b0, 3'd0, 4'b0000}));
    run_wait(90);
    chk("restart_result", res_of(0), int'({1'b1, 3'd0, 4'b0000}));

    // Start re-pulsed during SETTLE of vector 1.
    begin_run();
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_wait(90);
    chk("repulse_done_at_t+13", lat[0] + 1, 13);
    chk("repulse_result",       res_of(0), int'({1'b1, 3'd0, 4'b0000}));

    // Reset during SAMPLE of vector 2 (eight edges into the run).
    begin_run();
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun_reset", int'(got_of(0)), 0);
    begin_run();
    run_wait(90);
    chk("post_reset_done_at_t+13", lat[0] + 1, 13);
    chk("post_reset_result",       res_of(0), int'({1'b1, 3'd0, 4'b0000}));

    // Random start/reset/stuck-at traffic against the model.
    for (int n = 0; n < 600; n++) begin
      start = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 59) == 0);
      frc   = ($urandom_range(0, 3) == 0);
      tick();
    end
    start = 1'b0; rst = 1'b0; frc = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
